// File: rtl/dwt_subband_buffer_if.sv
// Stream bundle between the DWT stage, the subband buffer and its consumer.
// The buffer takes the slave modport; the driving environment takes the master modport.
interface dwt_subband_buffer_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] l_in;
    logic [DATA_W-1:0] h_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_band;
    logic              out_last;

    modport master (
        output in_valid, l_in, h_in, out_ready,
        input  in_ready, out_valid, out_data, out_band, out_last
    );

    modport slave (
        input  in_valid, l_in, h_in, out_ready,
        output in_ready, out_valid, out_data, out_band, out_last
    );
endinterface

// File: rtl/dwt_subband_buffer.sv
// Ping-pong row buffer turning interleaved L/H pairs into an all-L-then-all-H stream.
// Optional sticky overflow port is enabled by defining DWT_BUF_OVF_EN.
module dwt_subband_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    dwt_subband_buffer_if.slave  bus
`ifdef DWT_BUF_OVF_EN
    ,
    output logic                 overflow
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        READ_L,
        READ_H
    } state_e;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] lMem_q [2][DEPTH];
    logic [DATA_W-1:0] hMem_q [2][DEPTH];

    logic              wrBank_q;
    logic [ADDR_W-1:0] wrPtr_q;
    logic [1:0]        full_q, full_d;

    state_e            state_q, state_d;
    logic              rdBank_q, rdBank_d;
    logic [ADDR_W-1:0] rdPtr_q, rdPtr_d;

    logic              outValid_q, outBand_q, outLast_q;
    logic [DATA_W-1:0] outData_q;

    logic wrFire, wrDone, rdFire, rdDone;

    assign wrFire = bus.in_valid && !full_q[wrBank_q];
    assign wrDone = wrFire && (wrPtr_q == LAST);
    assign rdFire = outValid_q && bus.out_ready;
    assign rdDone = rdFire && (state_q == READ_H) && (rdPtr_q == LAST);

    assign bus.in_ready  = !full_q[wrBank_q];
    assign bus.out_valid = outValid_q;
    assign bus.out_data  = outData_q;
    assign bus.out_band  = outBand_q;
    assign bus.out_last  = outLast_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    lMem_q[b][i] <= '0;
                    hMem_q[b][i] <= '0;
                end
            end
            wrBank_q <= 1'b0;
            wrPtr_q  <= '0;
        end else if (wrFire) begin
            lMem_q[wrBank_q][wrPtr_q] <= bus.l_in;
            hMem_q[wrBank_q][wrPtr_q] <= bus.h_in;
            wrPtr_q                   <= wrPtr_q + ADDR_W'(1);
            if (wrDone) begin
                wrBank_q <= ~wrBank_q;
            end
        end
    end

    // A bank completing on the write side in the same cycle the read side frees the
    // other one counts as full, so back-to-back rows drain without an IDLE bubble.
    always_comb begin
        state_d  = state_q;
        rdPtr_d  = rdPtr_q;
        rdBank_d = rdBank_q;
        full_d   = full_q;
        if (wrDone) full_d[wrBank_q] = 1'b1;
        if (rdDone) full_d[rdBank_q] = 1'b0;
        case (state_q)
            IDLE: begin
                if (full_q[rdBank_q]) begin
                    state_d = READ_L;
                    rdPtr_d = '0;
                end
            end
            READ_L: begin
                if (rdFire) begin
                    rdPtr_d = rdPtr_q + ADDR_W'(1);
                    if (rdPtr_q == LAST) state_d = READ_H;
                end
            end
            READ_H: begin
                if (rdFire) begin
                    rdPtr_d = rdPtr_q + ADDR_W'(1);
                    if (rdPtr_q == LAST) begin
                        rdBank_d = ~rdBank_q;
                        state_d  = full_d[~rdBank_q] ? READ_L : IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are loaded from the next read position so they are pure flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rdBank_q   <= 1'b0;
            rdPtr_q    <= '0;
            full_q     <= 2'b00;
            outValid_q <= 1'b0;
            outBand_q  <= 1'b0;
            outLast_q  <= 1'b0;
            outData_q  <= '0;
        end else begin
            state_q    <= state_d;
            rdBank_q   <= rdBank_d;
            rdPtr_q    <= rdPtr_d;
            full_q     <= full_d;
            outValid_q <= (state_d != IDLE);
            outBand_q  <= (state_d == READ_H);
            outLast_q  <= (state_d == READ_H) && (rdPtr_d == LAST);
            if (state_d == READ_H) begin
                outData_q <= hMem_q[rdBank_d][rdPtr_d];
            end else if (state_d == READ_L) begin
                outData_q <= lMem_q[rdBank_d][rdPtr_d];
            end else begin
                outData_q <= '0;
            end
        end
    end

`ifdef DWT_BUF_OVF_EN
    logic overflow_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (bus.in_valid && full_q[wrBank_q]) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_dwt_subband_buffer.sv
// Self-checking bench for dwt_subband_buffer: a row-level scoreboard predicts the
// subband-ordered output, write-side readiness and the sticky overflow flag.
module tb_dwt_subband_buffer;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int BEAT_W = DATA_W + 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    dwt_subband_buffer_if #(.DATA_W(DATA_W)) bus ();

`ifdef DWT_BUF_OVF_EN
    logic overflow;
`endif

    dwt_subband_buffer #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
`ifdef DWT_BUF_OVF_EN
        ,
        .overflow(overflow)
`endif
    );

    int nChecks = 0;
    int nPass   = 0;
    int cycleNo = 0;

    // Reference model: rows are collected pair by pair; a finished row is queued as
    // its L words followed by its H words, each beat packed {last, band, data}.
    logic [BEAT_W-1:0] expQ [$];
    logic [DATA_W-1:0] rowL [$];
    logic [DATA_W-1:0] rowH [$];
    int  rowsDone    = 0;
    int  rowsDrained = 0;
    bit  modelOvf    = 1'b0;

    logic              sInReady, sOutValid, sOvf;
    logic [BEAT_W-1:0] sBeat = '0;
    logic [BEAT_W-1:0] pBeat = '0;
    logic [BEAT_W-1:0] eBeat;
    bit                eInReady, eOvf, xfer, eEmpty;
    bit                pStall = 1'b0;
    bit                pReady = 1'b0;

    task automatic applyReset(input int n);
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.l_in      = '0;
        bus.h_in      = '0;
        bus.out_ready = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        expQ.delete();
        rowL.delete();
        rowH.delete();
        rowsDone    = 0;
        rowsDrained = 0;
        modelOvf    = 1'b0;
        sOutValid   = 1'b0;
        pReady      = 1'b0;
        pStall      = 1'b0;
    endtask

    // Drives one cycle, samples the DUT at the falling edge and advances the model
    // over the rising edge that follows.
    task automatic applyStimulus(input bit iv, input logic [DATA_W-1:0] l,
                                 input logic [DATA_W-1:0] h, input bit ordy);
        bus.in_valid  = iv;
        bus.l_in      = l;
        bus.h_in      = h;
        bus.out_ready = ordy;
        pStall = sOutValid && !pReady;
        pBeat  = sBeat;
        @(negedge clk);
        sInReady  = bus.in_ready;
        sOutValid = bus.out_valid;
        sBeat     = {bus.out_last, bus.out_band, bus.out_data};
`ifdef DWT_BUF_OVF_EN
        sOvf = overflow;
`else
        sOvf = 1'b0;
`endif
        pReady   = ordy;
        eInReady = (rowsDone - rowsDrained) < 2;
        eOvf     = modelOvf;
        xfer     = sOutValid && ordy;
        eEmpty   = 1'b0;
        eBeat    = '0;
        if (xfer) begin
            if (expQ.size() == 0) begin
                eEmpty = 1'b1;
            end else begin
                eBeat = expQ.pop_front();
                if (eBeat[BEAT_W-1]) rowsDrained++;
            end
        end
        if (iv && !eInReady) modelOvf = 1'b1;
        if (iv && eInReady) begin
            rowL.push_back(l);
            rowH.push_back(h);
            if (rowL.size() == DEPTH) begin
                for (int i = 0; i < DEPTH; i++) expQ.push_back({1'b0, 1'b0, rowL[i]});
                for (int i = 0; i < DEPTH; i++) expQ.push_back({(i == DEPTH - 1), 1'b1, rowH[i]});
                rowL.delete();
                rowH.delete();
                rowsDone++;
            end
        end
        @(posedge clk);
        #1;
        cycleNo++;
    endtask

    task automatic test_reset();
        applyReset(2);
        @(negedge clk);
        nChecks++;
        if (bus.in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b want 1", bus.in_ready);
        else nPass++;
        nChecks++;
        if (bus.out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b want 0", bus.out_valid);
        else nPass++;
        nChecks++;
        if (bus.out_data !== '0) $display("[TB] FAIL reset_out_data: got %h want 00", bus.out_data);
        else nPass++;
        nChecks++;
        if (bus.out_last !== 1'b0 || bus.out_band !== 1'b0)
            $display("[TB] FAIL reset_last_band: got %b%b want 00", bus.out_last, bus.out_band);
        else nPass++;
`ifdef DWT_BUF_OVF_EN
        nChecks++;
        if (overflow !== 1'b0) $display("[TB] FAIL reset_overflow: got %b want 0", overflow);
        else nPass++;
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_row();
        int beats = 0;
        applyReset(1);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, DATA_W'(i), DATA_W'(8'h80 + i), 1'b1);
            nChecks++;
            if (sInReady !== eInReady)
                $display("[TB] FAIL row_in_ready cyc %0d: got %b want %b", cycleNo, sInReady, eInReady);
            else nPass++;
        end
        applyStimulus(1'b0, '0, '0, 1'b1);
        nChecks++;
        if (sOutValid !== 1'b0) $display("[TB] FAIL row_latency_early: got %b want 0", sOutValid);
        else nPass++;
        for (int k = 0; k < 40 && beats < 2 * DEPTH; k++) begin
            applyStimulus(1'b0, '0, '0, 1'b1);
            if (k == 0) begin
                nChecks++;
                if (sOutValid !== 1'b1) $display("[TB] FAIL row_latency_first: got %b want 1", sOutValid);
                else nPass++;
            end
            if (xfer) begin
                beats++;
                nChecks++;
                if (eEmpty || sBeat !== eBeat)
                    $display("[TB] FAIL row_beat %0d: got %h want %h (empty=%0d)", beats, sBeat, eBeat, eEmpty);
                else nPass++;
            end
        end
        nChecks++;
        if (beats !== 2 * DEPTH) $display("[TB] FAIL row_count: got %0d want %0d", beats, 2 * DEPTH);
        else nPass++;
    endtask

    task automatic test_stall();
        applyReset(1);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, DATA_W'($urandom), DATA_W'($urandom), 1'b1);
        for (int k = 0; k < 120 && expQ.size() > 0; k++) begin
            applyStimulus(1'b0, '0, '0, (k % 2) == 0);
            if (pStall) begin
                nChecks++;
                if (sOutValid !== 1'b1 || sBeat !== pBeat)
                    $display("[TB] FAIL stall_hold cyc %0d: got %b/%h want 1/%h", cycleNo, sOutValid, sBeat, pBeat);
                else nPass++;
            end
            if (xfer) begin
                nChecks++;
                if (eEmpty || sBeat !== eBeat)
                    $display("[TB] FAIL stall_beat cyc %0d: got %h want %h (empty=%0d)", cycleNo, sBeat, eBeat, eEmpty);
                else nPass++;
            end
        end
        nChecks++;
        if (expQ.size() != 0) $display("[TB] FAIL stall_drained: got %0d left want 0", expQ.size());
        else nPass++;
    endtask

    task automatic test_overflow();
        int gaps = 0;
        applyReset(1);
        for (int i = 0; i < 3 * DEPTH; i++) begin
            applyStimulus(1'b1, DATA_W'($urandom), DATA_W'($urandom), 1'b0);
            nChecks++;
            if (sInReady !== eInReady)
                $display("[TB] FAIL ovf_in_ready pair %0d: got %b want %b", i, sInReady, eInReady);
            else nPass++;
`ifdef DWT_BUF_OVF_EN
            nChecks++;
            if (sOvf !== eOvf) $display("[TB] FAIL ovf_flag pair %0d: got %b want %b", i, sOvf, eOvf);
            else nPass++;
`endif
        end
        applyStimulus(1'b0, '0, '0, 1'b0);
`ifdef DWT_BUF_OVF_EN
        nChecks++;
        if (sOvf !== 1'b1) $display("[TB] FAIL ovf_sticky: got %b want 1", sOvf);
        else nPass++;
`endif
        for (int k = 0; k < 4 * DEPTH; k++) begin
            applyStimulus(1'b0, '0, '0, 1'b1);
            if (!sOutValid) gaps++;
            if (xfer) begin
                nChecks++;
                if (eEmpty || sBeat !== eBeat)
                    $display("[TB] FAIL b2b_beat %0d: got %h want %h (empty=%0d)", k, sBeat, eBeat, eEmpty);
                else nPass++;
            end
        end
        nChecks++;
        if (gaps != 0) $display("[TB] FAIL b2b_gap: got %0d idle cycles want 0", gaps);
        else nPass++;
        nChecks++;
        if (expQ.size() != 0) $display("[TB] FAIL b2b_drained: got %0d left want 0", expQ.size());
        else nPass++;
    endtask

    task automatic test_reset_mid();
        int beats = 0;
        applyReset(1);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, DATA_W'($urandom), DATA_W'($urandom), 1'b1);
        for (int k = 0; k < 30 && beats < 5; k++) begin
            applyStimulus(k < 3, DATA_W'($urandom), DATA_W'($urandom), 1'b1);
            if (xfer) begin
                beats++;
                nChecks++;
                if (eEmpty || sBeat !== eBeat)
                    $display("[TB] FAIL mid_pre_beat %0d: got %h want %h", beats, sBeat, eBeat);
                else nPass++;
            end
        end
        applyReset(1);
        applyStimulus(1'b0, '0, '0, 1'b0);
        nChecks++;
        if (sOutValid !== 1'b0 || sInReady !== 1'b1 || sBeat !== '0)
            $display("[TB] FAIL mid_reset_state: got v=%b r=%b beat=%h want v=0 r=1 beat=000", sOutValid, sInReady, sBeat);
        else nPass++;
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, DATA_W'($urandom), DATA_W'($urandom), 1'b1);
        beats = 0;
        for (int k = 0; k < 40 && beats < 2 * DEPTH; k++) begin
            applyStimulus(1'b0, '0, '0, 1'b1);
            if (xfer) begin
                beats++;
                nChecks++;
                if (eEmpty || sBeat !== eBeat)
                    $display("[TB] FAIL mid_post_beat %0d: got %h want %h (empty=%0d)", beats, sBeat, eBeat, eEmpty);
                else nPass++;
            end
        end
        nChecks++;
        if (beats != 2 * DEPTH) $display("[TB] FAIL mid_post_count: got %0d want %0d", beats, 2 * DEPTH);
        else nPass++;
    endtask

    task automatic test_back_to_back();
        int  beats   = 0;
        int  gaps    = 0;
        bit  started = 1'b0;
        applyReset(1);
        for (int k = 0; k < 250 && beats < 6 * DEPTH; k++) begin
            bit iv;
            iv = ((k % 2) == 0) && (k < 6 * DEPTH);
            applyStimulus(iv, DATA_W'($urandom), DATA_W'($urandom), 1'b1);
            if (iv) begin
                nChecks++;
                if (sInReady !== 1'b1) $display("[TB] FAIL steady_in_ready cyc %0d: got %b want 1", cycleNo, sInReady);
                else nPass++;
            end
            if (sOutValid) started = 1'b1;
            else if (started) gaps++;
            if (xfer) begin
                beats++;
                nChecks++;
                if (eEmpty || sBeat !== eBeat)
                    $display("[TB] FAIL steady_beat %0d: got %h want %h (empty=%0d)", beats, sBeat, eBeat, eEmpty);
                else nPass++;
            end
        end
        nChecks++;
        if (beats != 6 * DEPTH || gaps != 0)
            $display("[TB] FAIL steady_stream: got %0d beats %0d gaps want %0d beats 0 gaps", beats, gaps, 6 * DEPTH);
        else nPass++;
    endtask

    task automatic test_random();
        applyReset(1);
        for (int k = 0; k < 400; k++) begin
            applyStimulus($urandom_range(0, 9) < 7, DATA_W'($urandom), DATA_W'($urandom),
                          $urandom_range(0, 9) < 6);
            nChecks++;
            if (sInReady !== eInReady)
                $display("[TB] FAIL rand_in_ready cyc %0d: got %b want %b", cycleNo, sInReady, eInReady);
            else nPass++;
            if (xfer) begin
                nChecks++;
                if (eEmpty || sBeat !== eBeat)
                    $display("[TB] FAIL rand_beat cyc %0d: got %h want %h (empty=%0d)", cycleNo, sBeat, eBeat, eEmpty);
                else nPass++;
            end
`ifdef DWT_BUF_OVF_EN
            nChecks++;
            if (sOvf !== eOvf) $display("[TB] FAIL rand_ovf cyc %0d: got %b want %b", cycleNo, sOvf, eOvf);
            else nPass++;
`endif
        end
        for (int k = 0; k < 150 && expQ.size() > 0; k++) begin
            applyStimulus(1'b0, '0, '0, 1'b1);
            if (xfer) begin
                nChecks++;
                if (eEmpty || sBeat !== eBeat)
                    $display("[TB] FAIL rand_drain_beat cyc %0d: got %h want %h", cycleNo, sBeat, eBeat);
                else nPass++;
            end
        end
        nChecks++;
        if (expQ.size() != 0) $display("[TB] FAIL rand_drained: got %0d left want 0", expQ.size());
        else nPass++;
    endtask

    initial begin
        $display("[TB] starting dwt_subband_buffer bench");
        test_reset();
        test_single_row();
        test_stall();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/dwt_subband_buffer.md
Name: dwt_subband_buffer

Overview:
- Sits directly downstream of the one-dimensional one-level DWT stage.
- Captures the interleaved low-pass/high-pass coefficient pairs (L_out/H_out) that stage produces for one row.
- Re-emits the row in subband order: all L coefficients, then all H coefficients, over a valid/ready stream. This feeds the next-level DWT pass or the output packer.
- Uses a two-bank (ping-pong) register store, so one row can be written while the previous row drains.

Parameters:
- DATA_W, 8, coefficient width in bits; matches the upstream stage.
- DEPTH, 16, coefficient pairs per row; must be a power of 2, at least 2.
- ADDR_W, 4, log2(DEPTH).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  l_in/h_in hold a valid pair this cycle.
- in_ready  output  1  the current write bank can accept a pair.
- l_in  input  DATA_W  low-pass coefficient (upstream L_out).
- h_in  input  DATA_W  high-pass coefficient (upstream H_out), two's complement.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  DATA_W  current coefficient.
- out_band  output  1  0 = L coefficient, 1 = H coefficient.
- out_last  output  1  high on the final H coefficient of a row.
- overflow  output  1  sticky dropped-pair flag; exists only with DWT_BUF_OVF_EN.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values:
  - wr_bank, rd_bank, wr_ptr and rd_ptr are 0; full[1:0] = 0; read FSM in IDLE.
  - All storage is 0.
  - Outputs: in_ready=1, out_valid=0, out_data=0, out_band=0, out_last=0, overflow=0.
- Storage: two banks, each holding DEPTH L words and DEPTH H words, implemented as registers (no RAM macro).
- Write side:
  - in_ready = !full[wr_bank].
  - On in_valid && in_ready: store l_in and h_in at wr_ptr of wr_bank, then increment wr_ptr.
  - When wr_ptr == DEPTH-1 on a write: wr_ptr wraps to 0, full[wr_bank] is set, wr_bank toggles.
  - in_valid while in_ready=0: the pair is dropped and no pointer changes.
- Read FSM, states IDLE, READ_L, READ_H:
  - IDLE: if full[rd_bank], go to READ_L with rd_ptr=0; otherwise stay.
  - READ_L: out_valid=1, out_band=0, out_data = L[rd_bank][rd_ptr]. On out_ready, rd_ptr increments; after index DEPTH-1, rd_ptr wraps to 0 and the FSM goes to READ_H.
  - READ_H: out_valid=1, out_band=1, out_data = H[rd_bank][rd_ptr], out_last = (rd_ptr == DEPTH-1). On out_ready at the last index:
    - clear full[rd_bank] and toggle rd_bank;
    - go to READ_L if the other bank is already full, otherwise go to IDLE.
- Handshake:
  - A beat transfers only when out_valid && out_ready.
  - While out_valid && !out_ready, out_data, out_band and out_last hold stable.
- Latency: if the final pair of a row is sampled at edge E, full is set at E, the FSM enters READ_L at E+1, and out_valid is high from E+1. A row takes 2*DEPTH accepted beats.
- Data: coefficients pass through bit-exact, with no sign extension or rounding. H values stay two's complement.
- Simultaneous events: a write completing bank A and a read freeing bank B in the same cycle both take effect. There is no stall and no lost flag update.
- Both banks full: in_ready=0 until the read side frees a bank. The freed bank is writable the cycle after its full flag clears.
- Reset mid-operation: returns to the reset state at the next edge. Any partial row and any undrained rows are discarded.

Optional Feature:
- Macro: DWT_BUF_OVF_EN.
- Defined: the overflow port exists. It is set at the edge where in_valid && !in_ready is sampled and stays set until reset.
- Undefined: the overflow port and its register are absent. Dropped pairs are discarded silently; all other behaviour is identical.

Test Plan:
1. Reset for 2 cycles -> in_ready=1, out_valid=0, out_data=0, out_last=0, overflow=0.
2. One row, DEPTH=16, l_in=i, h_in=8'h80+i for i=0..15, out_ready=1 -> out_data 0..15 with out_band=0, then 8'h80..8'h8F with out_band=1; out_last only on 8'h8F; first out_valid one edge after the 16th write.
3. Same row with out_ready toggling 1,0,1,0 -> out_data/out_band stable on every stalled cycle; all 32 values arrive in order with none duplicated.
4. out_ready=0, stream 48 pairs (rows A, B, C) -> in_ready drops after 32 pairs; row C is dropped; overflow=1 with the macro defined. Release out_ready -> rows A then B output back-to-back, with no IDLE cycle between A's out_last and B's first L.
5. Reset asserted after 5 accepted read beats -> next cycle out_valid=0, in_ready=1. A new row then streams from L index 0.
6. Steady state, in_valid every 2 cycles, out_ready=1 -> the bank-complete write and the bank-free read coincide; in_ready never drops; output is continuous across rows.
